// File: rtl/instr_sequencer.sv
// Issue controller for the DECODER/ALU pair: buffers instructions in a small FIFO,
// decodes one at a time, runs the ALU with a timeout and writes back into R0/R1.
module instr_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ena,
  input  logic       in_valid,
  input  logic [7:0] in_instr,
  output logic       in_ready,
  output logic       dec_ena,
  output logic [7:0] dec_instr,
  input  logic       dec_alu_enable,
  input  logic       dec_write_enable,
  input  logic       dec_reg_sel,
  output logic       alu_start,
  output logic [7:0] alu_a,
  input  logic       alu_done,
  input  logic [7:0] alu_result,
  output logic [7:0] r0,
  output logic [7:0] r1,
  output logic       flag_zero,
  output logic       busy,
  output logic       err,
  output logic [7:0] retired
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TIMER_W = $clog2(ALU_TIMEOUT);

  typedef enum logic [1:0] {IDLE, DEC, CHK, EXEC} state_t;

  state_t             state, state_next;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [7:0]         ir;
  logic               wr_q, sel_q;
  logic [TIMER_W-1:0] timer;
  logic               push, pop, timeout;

  assign in_ready  = !reset && (count != CNT_W'(FIFO_DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = (state == IDLE) && ena && (count != '0);
  assign timeout   = (timer == TIMER_W'(ALU_TIMEOUT - 1));

  assign dec_ena   = (state == DEC);
  assign dec_instr = (state == IDLE) ? 8'h00 : ir;
  assign alu_start = (state == CHK) && dec_alu_enable;
  assign busy      = (state != IDLE);

  // NOTE: storage is not reset; count gates every read, so stale entries are never observed.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  // NOTE: every register here uses <= so all updates see the pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: defaults are assigned first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = DEC;
      DEC:     state_next = CHK;
      CHK:     state_next = dec_alu_enable ? EXEC : IDLE;
      EXEC:    if (alu_done || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The operand is driven straight from the decoder in CHK, then from the latched select.
  always_comb begin
    alu_a = 8'h00;
    if (alu_start)          alu_a = dec_reg_sel ? r1 : r0;
    else if (state == EXEC) alu_a = sel_q ? r1 : r0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ir        <= 8'h00;
      wr_q      <= 1'b0;
      sel_q     <= 1'b0;
      timer     <= '0;
      r0        <= 8'h00;
      r1        <= 8'h00;
      flag_zero <= 1'b0;
      err       <= 1'b0;
      retired   <= 8'h00;
    end else begin
      state <= state_next;
      if (pop) ir <= mem[rd_ptr];
      if (alu_start) begin
        wr_q  <= dec_write_enable;
        sel_q <= dec_reg_sel;
        timer <= '0;
      end
      if (state == EXEC) begin
        timer <= timer + 1'b1;
        // Completion takes priority over a timeout landing on the same cycle.
        if (alu_done) begin
          if (wr_q) begin
            if (sel_q) r1 <= alu_result;
            else       r0 <= alu_result;
          end
          flag_zero <= (alu_result == 8'h00);
          retired   <= retired + 8'd1;
        end else if (timeout) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: decoder/ALU responders, a queue-based
// reference model compared every cycle, and directed scenarios with literal expectations.
module tb_instr_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_instr = 8'h00;
  logic       in_ready, dec_ena, alu_start, flag_zero, busy, err;
  logic [7:0] dec_instr, alu_a, r0, r1, retired;
  logic       dec_alu_enable = 1'b0, dec_write_enable = 1'b0, dec_reg_sel = 1'b0;
  logic       alu_done = 1'b0;
  logic [7:0] alu_result = 8'h00;

  int n_pass = 0;
  int n_total = 0;
  bit checking = 1'b0;
  bit spur_en = 1'b0;
  int alu_lat = 1;

  always #5 clock = ~clock;

  instr_sequencer #(.FIFO_DEPTH(DEPTH), .ALU_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .ena(ena), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .dec_ena(dec_ena), .dec_instr(dec_instr),
    .dec_alu_enable(dec_alu_enable), .dec_write_enable(dec_write_enable),
    .dec_reg_sel(dec_reg_sel), .alu_start(alu_start), .alu_a(alu_a),
    .alu_done(alu_done), .alu_result(alu_result), .r0(r0), .r1(r1),
    .flag_zero(flag_zero), .busy(busy), .err(err), .retired(retired)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMP (subtract, no write), 6/7 NOP.
  function automatic logic [7:0] alu_fn(input logic [7:0] instr, input logic [7:0] a);
    logic [7:0] b;
    b = {4'h0, instr[3:0]};
    case (instr[7:5])
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a - b;
      default: return 8'h00;
    endcase
  endfunction

  // Decoder responder: outputs registered one cycle after dec_ena.
  always @(posedge clock) begin
    if (reset) begin
      dec_alu_enable   <= 1'b0;
      dec_write_enable <= 1'b0;
      dec_reg_sel      <= 1'b0;
    end else begin
      dec_alu_enable   <= dec_ena && (dec_instr[7:5] < 3'd6);
      dec_write_enable <= dec_ena && (dec_instr[7:5] < 3'd5);
      dec_reg_sel      <= dec_ena && dec_instr[4];
    end
  end

  // ALU responder: done arrives alu_lat cycles after the start edge; 0 means never.
  int         pend = 0;
  logic [7:0] a_cap = 8'h00, i_cap = 8'h00;
  always @(posedge clock) begin
    alu_done <= 1'b0;
    if (!reset && alu_start === 1'b1) begin
      a_cap = alu_a;
      i_cap = dec_instr;
      pend  = alu_lat;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        alu_done   <= 1'b1;
        alu_result <= alu_fn(i_cap, a_cap);
      end
    end else if (spur_en && busy === 1'b0 && ($urandom % 8) == 0) begin
      alu_done   <= 1'b1;
      alu_result <= 8'($urandom);
    end
  end

  // Reference model: queue of pending instructions plus the age of the one in flight
  // (-1 none, 0 decode, 1 check, 2+ waiting on the ALU).
  logic [7:0] q[$];
  int         stage = -1;
  logic [7:0] cur = 8'h00;
  logic [7:0] m_r0 = 8'h00, m_r1 = 8'h00, m_ret = 8'h00;
  logic       m_zf = 1'b0, m_err = 1'b0;

  always @(posedge clock) begin : model
    bit         m_push, m_pop;
    logic [7:0] res;
    if (reset) begin
      q.delete();
      stage = -1; cur = 8'h00;
      m_r0 = 8'h00; m_r1 = 8'h00; m_ret = 8'h00; m_zf = 1'b0; m_err = 1'b0;
    end else begin
      m_push = in_valid && (q.size() != DEPTH);
      m_pop  = (stage == -1) && ena && (q.size() != 0);
      if (stage == -1) begin
        if (m_pop) begin
          cur   = q.pop_front();
          stage = 0;
        end
      end else if (stage == 0) begin
        stage = 1;
      end else if (stage == 1) begin
        stage = (cur[7:5] < 3'd6) ? 2 : -1;
      end else begin
        if (alu_done) begin
          res = alu_fn(cur, cur[4] ? m_r1 : m_r0);
          if (cur[7:5] != 3'd5) begin
            if (cur[4]) m_r1 = res;
            else        m_r0 = res;
          end
          m_zf  = (res == 8'h00);
          m_ret = m_ret + 8'd1;
          stage = -1;
        end else if (stage - 2 == TMO - 1) begin
          m_err = 1'b1;
          stage = -1;
        end else begin
          stage++;
        end
      end
      if (m_push) q.push_back(in_instr);
    end
  end

  always @(negedge clock) begin : compare
    logic       e_start;
    logic [7:0] e_a;
    if (checking) begin
      e_start = (stage == 1) && (cur[7:5] < 3'd6);
      e_a     = (e_start || stage >= 2) ? (cur[4] ? m_r1 : m_r0) : 8'h00;
      check("in_ready",  in_ready,  !reset && (q.size() != DEPTH));
      check("dec_ena",   dec_ena,   stage == 0);
      check("dec_instr", dec_instr, (stage >= 0) ? cur : 8'h00);
      check("alu_start", alu_start, e_start);
      check("alu_a",     alu_a,     e_a);
      check("r0",        r0,        m_r0);
      check("r1",        r1,        m_r1);
      check("flag_zero", flag_zero, m_zf);
      check("busy",      busy,      stage >= 0);
      check("err",       err,       m_err);
      check("retired",   retired,   m_ret);
    end
  end

  int n_starts = 0;
  int n_busy = 0;
  always @(negedge clock) begin
    if (alu_start === 1'b1) n_starts++;
    if (busy === 1'b1) n_busy++;
  end

  task automatic push(input logic [7:0] v);
    @(posedge clock); #1;
    in_valid = 1'b1;
    in_instr = v;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((busy !== 1'b0 || q.size() != 0) && n < 300);
    check({tag, "_idle"}, {busy, 1'b0}, 2'b00);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (alu_start !== 1'b1 && n < 30) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_start_seen"}, alu_start, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         s0, b0, cnt;
    logic [7:0] t5 [5];
    t5 = '{8'h01, 8'h12, 8'h47, 8'h71, 8'h02};

    repeat (2) @(posedge clock);
    checking = 1'b1;
    @(negedge clock);
    check("rst_in_ready",  in_ready,  1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_retired",   retired,   8'h00);
    check("rst_dec_instr", dec_instr, 8'h00);
    @(posedge clock); #1;
    reset = 1'b0;
    ena   = 1'b1;
    @(negedge clock);
    check("ready_after_reset", in_ready, 1'b1);

    // ADD R0,3: pushed at edge N, decode in N+2, start in N+3, done the cycle after.
    @(posedge clock); #1;
    in_valid = 1'b1;
    in_instr = 8'h03;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check("t1_idle_n1", busy, 1'b0);
    @(negedge clock);
    check("t1_dec_ena_n2", dec_ena, 1'b1);
    check("t1_dec_instr",  dec_instr, 8'h03);
    @(negedge clock);
    check("t1_start_n3", alu_start, 1'b1);
    check("t1_alu_a",    alu_a, 8'h00);
    @(negedge clock);
    check("t1_exec_busy", busy, 1'b1);
    @(negedge clock);
    check("t1_r0",      r0, 8'h03);
    check("t1_retired", retired, 8'd1);
    check("t1_zero",    flag_zero, 1'b0);
    check("t1_idle",    busy, 1'b0);

    // ADD R1,5 then SUB R1,5.
    push(8'h15);
    wait_idle("t2a");
    check("t2_r1_5", r1, 8'h05);
    push(8'h35);
    wait_idle("t2b");
    check("t2_r1_0", r1, 8'h00);
    check("t2_zero", flag_zero, 1'b1);
    check("t2_r0",   r0, 8'h03);

    // CMP R0,5 with R0=3: result 0xFE, no write.
    s0 = n_starts;
    push(8'hA5);
    wait_idle("t3");
    check("t3_started", n_starts - s0, 1);
    check("t3_r0",      r0, 8'h03);
    check("t3_r1",      r1, 8'h00);
    check("t3_zero",    flag_zero, 1'b0);
    check("t3_retired", retired, 8'd4);

    // NOP: decode and check only.
    s0 = n_starts;
    b0 = n_busy;
    push(8'hE0);
    wait_idle("t4");
    check("t4_no_start",   n_starts - s0, 0);
    check("t4_busy_cycles", n_busy - b0, 2);
    check("t4_retired",    retired, 8'd4);

    // Fill with ena low; the fifth push must be refused.
    @(posedge clock); #1;
    ena = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_instr = t5[i];
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    @(negedge clock);
    check("t5_full",      in_ready, 1'b0);
    check("t5_held_idle", busy, 1'b0);
    @(posedge clock); #1;
    ena = 1'b1;
    wait_idle("t5");
    check("t5_r0",      r0, 8'h04);
    check("t5_r1",      r1, 8'h03);
    check("t5_retired", retired, 8'd8);

    // ALU never answers: abort after 16 EXEC cycles with no write.
    alu_lat = 0;
    push(8'h01);
    wait_start("t6");
    cnt = 0;
    @(negedge clock);
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clock);
    end
    check("t6_exec_cycles", cnt, TMO);
    check("t6_err",     err, 1'b1);
    check("t6_r0",      r0, 8'h04);
    check("t6_retired", retired, 8'd8);

    // Reset in EXEC; the late alu_done must be ignored.
    alu_lat = 3;
    push(8'h01);
    wait_start("t7");
    @(posedge clock); #1;
    ena   = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("t7_r0",       r0, 8'h00);
    check("t7_r1",       r1, 8'h00);
    check("t7_err",      err, 1'b0);
    check("t7_busy",     busy, 1'b0);
    check("t7_retired",  retired, 8'h00);
    check("t7_alu_a",    alu_a, 8'h00);
    check("t7_in_ready", in_ready, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("t7_late_done", alu_done, 1'b1);
    @(negedge clock);
    check("t7_r0_after",      r0, 8'h00);
    check("t7_retired_after", retired, 8'h00);

    // Randomized traffic against the model.
    spur_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clock); #1;
      ena      = 1'(($urandom % 4) != 0);
      in_valid = 1'($urandom % 2);
      in_instr = 8'($urandom);
      if (($urandom % 8) == 0) alu_lat = (($urandom % 20) == 0) ? 0 : int'($urandom_range(1, 5));
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    spur_en  = 1'b0;
    ena      = 1'b1;
    alu_lat  = 1;
    wait_idle("drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Issue controller for the DECODER/ALU datapath.
- Buffers incoming 8-bit instructions in a small FIFO and feeds them one at a time to DECODER.
- Starts the ALU, waits for completion, then writes the result back to the R0/R1 register pair it owns.
- Sits between the host/serial instruction source and the DECODER + ALU pair. Adds flow control, an ALU timeout and status counters.

Parameters:
FIFO_DEPTH, 4, instruction FIFO entries (power of 2, ≥2)
ALU_TIMEOUT, 16, max cycles waiting for alu_done before abort (≥2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
ena  in  1  when 0, no new instruction is popped; in-flight instruction completes
in_valid  in  1  instruction offered
in_instr  in  8  instruction: [7:5] opcode, [4] reg_sel, [3:0] operand
in_ready  out  1  FIFO not full
dec_ena  out  1  DECODER ena
dec_instr  out  8  DECODER instr_in
dec_alu_enable  in  1  DECODER alu_enable (registered, valid 1 cycle after dec_ena)
dec_write_enable  in  1  DECODER write_enable
dec_reg_sel  in  1  DECODER reg_sel
alu_start  out  1  one-cycle ALU start pulse
alu_a  out  8  selected register value, held stable until alu_done or abort
alu_done  in  1  ALU completion
alu_result  in  8  ALU result, valid with alu_done
r0  out  8  register R0
r1  out  8  register R1
flag_zero  out  1  last completed ALU result == 0
busy  out  1  FSM not in IDLE
err  out  1  sticky ALU timeout flag
retired  out  8  completed ALU operations, wraps 255→0

Behaviour:
- Reset: FIFO flushed (count 0), FSM=IDLE, ir=0.
- All outputs 0 during reset. in_ready is 1 on the first cycle after reset.
- Reset mid-operation aborts everything immediately; no write-back occurs.
- FIFO push: on in_valid && in_ready.
- in_ready = (count != FIFO_DEPTH). No push when full.
- Push and pop on the same edge leave count unchanged.
- No fall-through: a pushed entry is poppable the cycle after its push.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, DEC, CHK, EXEC.
- IDLE: if ena && count != 0, pop head into ir → DEC. Otherwise stay.
- DEC (1 cycle): dec_ena=1, dec_instr=ir → CHK.
- dec_instr holds ir in DEC/CHK/EXEC and is 0 in IDLE. dec_ena=0 outside DEC.
- CHK (1 cycle): sample the decoder outputs.
  - If dec_alu_enable=0 (NOP/undefined opcode 110/111): → IDLE. No ALU start; retired unchanged.
  - Otherwise: latch wr=dec_write_enable and sel=dec_reg_sel. Drive alu_start=1 and alu_a = sel ? R1 : R0. Clear timer → EXEC.
- EXEC: timer increments each cycle. alu_a stays held.
  - On alu_done: if wr, R[sel] ← alu_result (CMP has wr=0, no write). flag_zero ← (alu_result==0). retired += 1 → IDLE.
  - If timer reaches ALU_TIMEOUT-1 without alu_done: err ← 1, no write, flags unchanged → IDLE.
  - alu_done and timeout on the same cycle: done wins.
- alu_done outside EXEC is ignored.
- Minimum per-instruction latency: IDLE→DEC→CHK→EXEC with alu_done on the first EXEC cycle = 4 cycles. Back-to-back throughput is 1 instruction per 4 cycles.
- busy = (state != IDLE).
- Changing ena mid-instruction does not stall the FSM.
- err clears only on reset.
- All arithmetic is 8-bit unsigned. retired wraps modulo 256.

Test Plan:
- After reset, push 0x03 (ADD R0,3) at edge N with an ALU model returning a+b one cycle after start. Required: dec_ena high in cycle N+2, alu_start high in cycle N+3 with alu_a=0, r0=3, retired=1, flag_zero=0.
- Push 0x15 (ADD R1,5), then 0x35 (SUB R1,5). Required: r1=5, then r1=0, flag_zero=1, r0 unchanged.
- Push 0xA5 (CMP 5) with R0=3. Required: alu_start asserted, r0/r1 unchanged, flag_zero updated from the result, retired incremented.
- Push 0xE0 (NOP). Required: no alu_start, busy for 2 cycles (DEC, CHK), retired unchanged.
- With ena=0, push 5 instructions (FIFO_DEPTH=4). Required: in_ready=0 after 4 pushes, busy=0. Set ena=1: all 4 execute in order.
- Hold alu_done=0 after a start. Required: err=1 after 16 EXEC cycles, no register write, FSM in IDLE. Assert reset during EXEC: all outputs 0 on the next cycle, and a subsequent alu_done is ignored.
